// File: rtl/hc595_frame_rx.sv
// Receiver for a 74HC595 serial display link: oversamples ds/shcp/stcp/oe on sys_clk,
// rebuilds the shift/storage word, decodes 7-segment digits and flags malformed frames.
module hc595_frame_rx #(
  parameter int SEL_WIDTH   = 6,
  parameter int SEG_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   ds,
  input  logic                   shcp,
  input  logic                   stcp,
  input  logic                   oe,
  output logic [SEL_WIDTH-1:0]   sel_q,
  output logic [SEG_WIDTH-1:0]   seg_q,
  output logic                   latch_pulse,
  output logic [4*SEL_WIDTH-1:0] digit_code,
  output logic [SEL_WIDTH-1:0]   dp_flags,
  output logic                   scan_done,
  output logic                   err_len,
  output logic                   err_sel
);

  localparam int         WORD_W    = SEL_WIDTH + SEG_WIDTH;
  localparam logic [3:0] FRAME_LEN = 4'(WORD_W);

  // Synchroniser chain, bit order {oe, stcp, shcp, ds}
  logic [3:0]                   pin_vec;
  logic [SYNC_STAGES-1:0][3:0]  sync_reg;
  logic [3:0]                   sync_last;
  logic [1:0]                   hist_reg;
  logic                         shcp_rise_reg;
  logic                         stcp_rise_reg;
  logic                         ds_reg;
  logic                         oe_sync;

  assign pin_vec   = {oe, stcp, shcp, ds};
  assign sync_last = sync_reg[SYNC_STAGES-1];
  assign oe_sync   = sync_last[3];

  // ds is registered alongside the edge flags so the shifted bit lines up with its shcp rise
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_reg      <= '0;
      hist_reg      <= '0;
      shcp_rise_reg <= 1'b0;
      stcp_rise_reg <= 1'b0;
      ds_reg        <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], pin_vec};
      hist_reg      <= sync_last[2:1];
      shcp_rise_reg <= sync_last[1] & ~hist_reg[0];
      stcp_rise_reg <= sync_last[2] & ~hist_reg[1];
      ds_reg        <= sync_last[0];
    end
  end

  // Shift register, bit counter and storage register
  logic [WORD_W-1:0] sr_reg;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] word_next;
  logic [3:0]        cnt_reg;

  assign word_next = stcp_rise_reg ? sr_reg : word_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr_reg      <= '0;
      cnt_reg     <= '0;
      word_reg    <= {{SEG_WIDTH{1'b1}}, {SEL_WIDTH{1'b0}}};
      latch_pulse <= 1'b0;
      err_len     <= 1'b0;
      sel_q       <= '0;
      seg_q       <= '1;
    end else begin
      if (shcp_rise_reg)
        sr_reg <= {sr_reg[WORD_W-2:0], ds_reg};
      // A simultaneous shift lands in the new frame, so the count restarts at 1
      if (stcp_rise_reg)
        cnt_reg <= {3'b000, shcp_rise_reg};
      else if (shcp_rise_reg && cnt_reg != 4'hF)
        cnt_reg <= cnt_reg + 4'd1;
      word_reg    <= word_next;
      latch_pulse <= stcp_rise_reg;
      err_len     <= stcp_rise_reg && (cnt_reg != FRAME_LEN);
      sel_q       <= oe_sync ? '0 : word_next[SEL_WIDTH-1:0];
      seg_q       <= oe_sync ? '1 : word_next[WORD_W-1:SEL_WIDTH];
    end
  end

  // Decode stage, one cycle behind latch_pulse
  logic [SEG_WIDTH-1:0] seg_field;
  logic [SEL_WIDTH-1:0] sel_field;
  logic [SEL_WIDTH-1:0] sel_minus1;
  logic                 sel_onehot;
  logic                 dec_go;
  logic                 dec_ok;
  logic [3:0]           seg_code;
  logic [SEL_WIDTH-1:0] mask_reg;
  logic [SEL_WIDTH-1:0] mask_next;
  logic                 scan_hit;

  assign seg_field  = word_reg[WORD_W-1:SEL_WIDTH];
  assign sel_field  = word_reg[SEL_WIDTH-1:0];
  assign sel_minus1 = sel_field - {{(SEL_WIDTH-1){1'b0}}, 1'b1};
  assign sel_onehot = (sel_field != '0) && ((sel_field & sel_minus1) == '0);
  assign dec_go     = latch_pulse & ~err_len;
  assign dec_ok     = dec_go & sel_onehot;
  assign mask_next  = mask_reg | sel_field;
  assign scan_hit   = dec_ok && (mask_next == '1);

  always_comb begin
    seg_code = 4'hF;
    case (seg_field[6:0])
      7'h40:   seg_code = 4'h0;
      7'h79:   seg_code = 4'h1;
      7'h24:   seg_code = 4'h2;
      7'h30:   seg_code = 4'h3;
      7'h19:   seg_code = 4'h4;
      7'h12:   seg_code = 4'h5;
      7'h02:   seg_code = 4'h6;
      7'h78:   seg_code = 4'h7;
      7'h00:   seg_code = 4'h8;
      7'h10:   seg_code = 4'h9;
      7'h7F:   seg_code = 4'hA;
      7'h3F:   seg_code = 4'hB;
      default: seg_code = 4'hF;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mask_reg  <= '0;
      scan_done <= 1'b0;
      err_sel   <= 1'b0;
    end else begin
      err_sel   <= dec_go & ~sel_onehot;
      scan_done <= scan_hit;
      if (dec_ok)
        mask_reg <= scan_hit ? '0 : mask_next;
    end
  end

  generate
    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_digit
      logic [3:0] code_reg;
      logic       dp_reg;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          code_reg <= 4'hA;
          dp_reg   <= 1'b0;
        end else if (dec_ok && sel_field[gi]) begin
          code_reg <= seg_code;
          dp_reg   <= ~seg_field[SEG_WIDTH-1];
        end
      end

      assign digit_code[4*gi +: 4] = code_reg;
      assign dp_flags[gi]          = dp_reg;
    end
  endgenerate

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Table-driven bench for hc595_frame_rx: frames are bit-banged onto the pins, expected
// latch/decode results are queued at stcp time and checked when latch_pulse appears.
module tb_hc595_frame_rx;

  localparam int SS = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b0;
  logic [5:0]  sel_q;
  logic [7:0]  seg_q;
  logic        latch_pulse;
  logic [23:0] digit_code;
  logic [5:0]  dp_flags;
  logic        scan_done, err_len, err_sel;

  always #5 sys_clk = ~sys_clk;

  hc595_frame_rx #(.SEL_WIDTH(6), .SEG_WIDTH(8), .SYNC_STAGES(SS)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .sel_q(sel_q), .seg_q(seg_q), .latch_pulse(latch_pulse), .digit_code(digit_code),
    .dp_flags(dp_flags), .scan_done(scan_done), .err_len(err_len), .err_sel(err_sel)
  );

  typedef struct packed {
    logic [14:0] bits;
    int          nbits;
    logic        oe_v;
    logic [5:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_len;
    logic        e_serr;
    logic [23:0] e_code;
    logic [5:0]  e_dp;
    logic        e_scan;
    int          t;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  vec_t exp_q[$];
  vec_t dec_exp;
  bit   dec_pending = 1'b0;
  vec_t tbl[12];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [14:0] w(input logic [7:0] seg, input logic [5:0] sel);
    return {1'b0, seg, sel};
  endfunction

  function automatic vec_t mk(input logic [14:0] bits, input int nbits, input logic oe_v,
                              input logic [5:0] s, input logic [7:0] g, input logic el,
                              input logic es, input logic [23:0] c, input logic [5:0] d,
                              input logic sc);
    vec_t v;
    v.bits = bits; v.nbits = nbits; v.oe_v = oe_v; v.e_sel = s; v.e_seg = g;
    v.e_len = el; v.e_serr = es; v.e_code = c; v.e_dp = d; v.e_scan = sc; v.t = 0;
    return v;
  endfunction

  // Scoreboard: latch-stage checks on latch_pulse, decode-stage checks one cycle later
  always @(negedge sys_clk) begin
    if (dec_pending) begin
      chk("err_sel", {31'b0, err_sel}, {31'b0, dec_exp.e_serr});
      chk("digit_code", {8'b0, digit_code}, {8'b0, dec_exp.e_code});
      chk("dp_flags", {26'b0, dp_flags}, {26'b0, dec_exp.e_dp});
      chk("scan_done", {31'b0, scan_done}, {31'b0, dec_exp.e_scan});
      $display("frame decoded: code=%h dp=%h scan=%b err_sel=%b", digit_code, dp_flags, scan_done, err_sel);
      dec_pending = 1'b0;
    end
    if (latch_pulse) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_latch: got latch_pulse=1 expected 0 (cycle %0d)", cyc);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("latency", cyc - e.t, SS + 2);
        chk("sel_q", {26'b0, sel_q}, {26'b0, e.e_sel});
        chk("seg_q", {24'b0, seg_q}, {24'b0, e.e_seg});
        chk("err_len", {31'b0, err_len}, {31'b0, e.e_len});
        $display("frame latched: sel_q=%h seg_q=%h err_len=%b", sel_q, seg_q, err_len);
        dec_exp     = e;
        dec_pending = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    tick(2);
    shcp = 1'b1;
    tick(2);
    shcp = 1'b0;
    tick(2);
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(posedge sys_clk);
      k++;
    end while ((exp_q.size() != 0 || dec_pending) && k < 40);
    n_chk++;
    if (exp_q.size() != 0 || dec_pending) begin
      n_fail++;
      $display("FAIL frame_timeout: got %0d queued expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic latch(input vec_t e);
    e.t = cyc;
    exp_q.push_back(e);
    stcp = 1'b1;
    tick(2);
    stcp = 1'b0;
    tick(2);
  endtask

  task automatic send(input vec_t v);
    tick(1);
    oe = v.oe_v;
    for (int i = v.nbits - 1; i >= 0; i--) shift_bit(v.bits[i]);
    latch(v);
    wait_done();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sel_q"}, {26'b0, sel_q}, 32'h0);
    chk({tag, "_seg_q"}, {24'b0, seg_q}, 32'hFF);
    chk({tag, "_digit_code"}, {8'b0, digit_code}, 32'hAAAAAA);
    chk({tag, "_dp_flags"}, {26'b0, dp_flags}, 32'h0);
    chk({tag, "_pulses"}, {28'b0, latch_pulse, scan_done, err_len, err_sel}, 32'h0);
    $display("%s state: sel_q=%h seg_q=%h code=%h dp=%h", tag, sel_q, seg_q, digit_code, dp_flags);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e1, e2, er;
    logic [14:0] word1, word2;

    tbl[0]  = mk(w(8'hA4, 6'h04), 14, 1'b0, 6'h04, 8'hA4, 1'b0, 1'b0, 24'hAAA2AA, 6'h00, 1'b0);
    tbl[1]  = mk(w(8'hF9, 6'h01), 14, 1'b0, 6'h01, 8'hF9, 1'b0, 1'b0, 24'hAAA2A1, 6'h00, 1'b0);
    tbl[2]  = mk(w(8'hA4, 6'h02), 14, 1'b0, 6'h02, 8'hA4, 1'b0, 1'b0, 24'hAAA221, 6'h00, 1'b0);
    tbl[3]  = mk(w(8'hB0, 6'h04), 14, 1'b0, 6'h04, 8'hB0, 1'b0, 1'b0, 24'hAAA321, 6'h00, 1'b0);
    tbl[4]  = mk(w(8'h19, 6'h08), 14, 1'b0, 6'h08, 8'h19, 1'b0, 1'b0, 24'hAA4321, 6'h08, 1'b0);
    tbl[5]  = mk(w(8'h92, 6'h10), 14, 1'b0, 6'h10, 8'h92, 1'b0, 1'b0, 24'hA54321, 6'h08, 1'b0);
    tbl[6]  = mk(w(8'h82, 6'h20), 14, 1'b0, 6'h20, 8'h82, 1'b0, 1'b0, 24'h654321, 6'h08, 1'b1);
    tbl[7]  = mk(15'h1001,        13, 1'b0, 6'h01, 8'h40, 1'b1, 1'b0, 24'h654321, 6'h08, 1'b0);
    tbl[8]  = mk(15'h7E41,        15, 1'b0, 6'h01, 8'hF9, 1'b1, 1'b0, 24'h654321, 6'h08, 1'b0);
    tbl[9]  = mk(w(8'h80, 6'h03), 14, 1'b0, 6'h03, 8'h80, 1'b0, 1'b1, 24'h654321, 6'h08, 1'b0);
    tbl[10] = mk(w(8'hFF, 6'h04), 14, 1'b0, 6'h04, 8'hFF, 1'b0, 1'b0, 24'h654A21, 6'h08, 1'b0);
    tbl[11] = mk(w(8'hC0, 6'h01), 14, 1'b1, 6'h00, 8'hFF, 1'b0, 1'b0, 24'h654A20, 6'h08, 1'b0);

    tick(3);
    sys_rst = 1'b0;
    tick(1);
    check_reset_state("reset");

    for (int i = 0; i < 12; i++) send(tbl[i]);

    // Release oe: stored word reappears SYNC_STAGES+1 cycles later
    tick(1);
    oe = 1'b0;
    tick(SS);
    chk("oe_lag_sel_q", {26'b0, sel_q}, 32'h0);
    tick(1);
    chk("oe_release_sel_q", {26'b0, sel_q}, 32'h01);
    chk("oe_release_seg_q", {24'b0, seg_q}, 32'hC0);
    $display("oe released: sel_q=%h seg_q=%h", sel_q, seg_q);

    // shcp and stcp together: latch sees the pre-shift word, count restarts at 1
    word1 = w(8'h90, 6'h08);
    word2 = w(8'h99, 6'h20);
    e1 = mk(word1, 14, 1'b0, 6'h08, 8'h90, 1'b0, 1'b0, 24'h659A20, 6'h00, 1'b0);
    e2 = mk(word2, 14, 1'b0, 6'h20, 8'h99, 1'b0, 1'b0, 24'h459A20, 6'h00, 1'b0);
    for (int i = 13; i >= 0; i--) shift_bit(word1[i]);
    ds = word2[13];
    tick(2);
    e1.t = cyc;
    exp_q.push_back(e1);
    shcp = 1'b1;
    stcp = 1'b1;
    tick(2);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(2);
    wait_done();
    tick(1);
    for (int i = 12; i >= 0; i--) shift_bit(word2[i]);
    latch(e2);
    wait_done();

    // Reset in the middle of a frame discards the partial bits
    tick(1);
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    sys_rst = 1'b1;
    tick(1);
    check_reset_state("midframe_reset");
    sys_rst = 1'b0;
    er = mk(w(8'hF9, 6'h01), 14, 1'b0, 6'h01, 8'hF9, 1'b0, 1'b0, 24'hAAAAA1, 6'h00, 1'b0);
    send(er);

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hc595_frame_rx.md
Name: hc595_frame_rx

Overview:
- Receiving end of the 74HC595 serial display link (ds/shcp/stcp/oe) driven by the freq_meter display path.
- Oversamples the link on sys_clk and rebuilds the 14-bit shift/storage register.
- Decodes the active-low 7-segment pattern and the one-hot digit select into per-digit codes.
- Serves as a bench monitor and as an on-chip loopback checker; reports malformed frames.

Parameters:
- SEL_WIDTH, 6, number of digit-select bits, one-hot active-high; sel[0] is the rightmost digit.
- SEG_WIDTH, 8, segment bits, active-low; seg[7] is dp, seg[6:0] is g..a.
- SYNC_STAGES, 2, synchroniser flops on each of ds/shcp/stcp/oe (minimum 2).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- ds  in  1  serial data.
- shcp  in  1  shift clock, rising-edge active.
- stcp  in  1  storage latch clock, rising-edge active.
- oe  in  1  output enable, active-low.
- sel_q  out  6  latched select; forced 0 while oe is high.
- seg_q  out  8  latched segments; forced 8'hFF while oe is high.
- latch_pulse  out  1  one-cycle pulse when storage updates.
- digit_code  out  24  {d5,...,d0}, 4 bits per digit.
- dp_flags  out  6  decimal point per digit, active-high.
- scan_done  out  1  one-cycle pulse when all 6 digits are refreshed.
- err_len  out  1  one-cycle pulse: frame bit count not equal to 14.
- err_sel  out  1  one-cycle pulse: latched sel not one-hot.

Behaviour:
- Reset: sel_q=0, seg_q=8'hFF, digit_code=24'hAAAAAA (all blank), dp_flags=0, all pulses 0.
- Reset also clears: shift register, bit counter, refresh mask, and synchroniser/edge history (history is set to 0).
- Synchronous reset overrides everything, including mid-frame; a partial frame in progress is discarded.
- Inputs are asynchronous: each passes through SYNC_STAGES flops.
- Edges are detected on the last sync stage against a one-cycle-delayed copy.
- Legal stimulus: shcp/stcp high and low ≥2 sys_clk each; ds stable ≥2 sys_clk before the shcp rise.
- Shift: on a detected shcp rise, sr <= {sr[12:0], ds_sync}. Bit counter increments and saturates at 15.
- Latch: on a detected stcp rise, word W = sr, with sel = W[5:0] and seg = W[13:6].
  - sel_q/seg_q and latch_pulse update on the cycle after the edge is detected.
  - Total latency from pin edge to latch_pulse is SYNC_STAGES+2 sys_clk.
  - The bit counter clears to 0.
- shcp and stcp rise in the same cycle: the latch takes the pre-shift sr, as a real 595 does. The counter becomes 1.
- Length check: if the count at latch is not 14, pulse err_len, still update sel_q/seg_q, and skip digit decode.
- Decode stage runs one cycle after latch_pulse.
  - If sel is not one-hot (0 or ≥2 bits set): pulse err_sel; no digit update.
  - Otherwise, the digit index i = position of the set bit.
  - seg[6:0] maps to a code:
    - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9.
    - 7F (all off)→A (blank), 3F→B (minus), anything else→F (invalid).
  - Lookup is on the 7-bit field with seg[7] excluded (values shown are with dp off).
  - d_i <= code; dp_flags[i] <= ~seg[7]; set refresh mask bit i.
- Scan complete: when the refresh mask reaches 6'h3F, pulse scan_done in the same cycle as that last digit update and clear the mask.
  - A repeat refresh of an already-set digit only overwrites that digit; it does not advance the scan.
- oe: gates only sel_q/seg_q. Decoding and the digit registers proceed regardless of oe.

Test Plan:
- Shift 14 bits {seg=8'hA4, sel=6'b000100}, then stcp.
  - latch_pulse fires SYNC_STAGES+2 cycles after the stcp rise; sel_q=6'h04, seg_q=8'hA4.
  - Next cycle: digit_code[11:8]=2, dp_flags=0, no errors.
- Six frames writing 1,2,3,4,5,6 to digits 0..5, with dp on digit 3 (seg=8'h19).
  - scan_done pulses once, with the last digit update.
  - digit_code=24'h654321, dp_flags=6'b001000.
- Frame of 13 shifts then stcp → err_len=1, seg_q/sel_q updated, digit_code unchanged.
- Frame of 15 shifts then stcp → err_len=1.
- sel=6'b000011 → err_sel=1, no update. Separately, seg=8'hFF on digit 2 → digit_code[11:8]=A.
- oe held high during a valid frame → sel_q=0 and seg_q=FF, but digit_code updates.
  - Release oe → sel_q/seg_q show the stored values after SYNC_STAGES+1 cycles.
- shcp and stcp rising together after 14 shifts → latch holds the pre-shift word (no err_len), counter=1.
  - Assert sys_rst mid-frame → all outputs return to their reset values on the next clock.
